// File: rtl/tile_pkg.sv
// Shared tile ROM types and defaults for the tile/sprite ROM arbiter.
package tile_pkg;

  localparam int unsigned TILE_ADDR_W  = 10;
  localparam int unsigned TILE_DATA_W  = 4;
  localparam int unsigned TILE_NREQ    = 4;
  localparam int unsigned TILE_ROM_LAT = 1;

  typedef logic [TILE_ADDR_W-1:0] tile_addr_t;
  typedef logic [TILE_DATA_W-1:0] tile_pix_t;

  // Round-robin successor of w in 0..n-1.
  function automatic int unsigned rr_next(input int unsigned w, input int unsigned n);
    return (w + 1 >= n) ? 0 : w + 1;
  endfunction

endpackage

// File: rtl/tile_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping mod NREQ.
module tile_rr_pick #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [PTR_W-1:0] w_o
);

  int unsigned      idx;
  logic [PTR_W-1:0] sel;
  logic             found;

  always_comb begin
    gnt_o = '0;
    w_o   = '0;
    idx   = 0;
    sel   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr_i) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = PTR_W'(idx);
      if (!found && req_i[sel]) begin
        found      = 1'b1;
        gnt_o[sel] = 1'b1;
        w_o        = sel;
      end
    end
  end

endmodule

// File: rtl/tile_rom_arbiter.sv
// Shares one synchronous tile ROM among NREQ requesters; a tag pipe aligned to ROM latency
// routes every returned word back to the requester that issued the address.
module tile_rom_arbiter
  import tile_pkg::*;
#(
  parameter int unsigned NREQ    = TILE_NREQ,
  parameter int unsigned ADDR_W  = TILE_ADDR_W,
  parameter int unsigned DATA_W  = TILE_DATA_W,
  parameter int unsigned ROM_LAT = TILE_ROM_LAT
) (
  input  logic                     vga_clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  output logic [NREQ-1:0]          gnt,
  output logic [ADDR_W-1:0]        rom_address,
  input  logic [DATA_W-1:0]        rom_q,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_data
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NREQ-1:0]   tag_q [ROM_LAT+1];
  logic [NREQ-1:0]   tag0_d;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic [NREQ-1:0]   pick_gnt;
  logic [PTR_W-1:0]  win;
  logic              any_gnt;

  tile_rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .w_o   (win)
  );

  // Grant is suppressed while reset is held so nothing is issued into a clearing pipe.
  assign gnt     = reset ? '0 : pick_gnt;
  assign any_gnt = |gnt;

  always_comb begin
    ptr_d      = ptr_q;
    addr_d     = addr_q;
    tag0_d     = '0;
    rsp_data_d = rsp_data_q;
    if (any_gnt) begin
      ptr_d  = PTR_W'(rr_next(32'(win), NREQ));
      addr_d = req_addr[32'(win)*ADDR_W +: ADDR_W];
      tag0_d = gnt;
    end
    // A zero ROM word is a real (transparent) index, so only the tag decides capture.
    if (|tag_q[ROM_LAT]) rsp_data_d = rom_q;
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      ptr_q       <= '0;
      addr_q      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      for (int unsigned i = 0; i <= ROM_LAT; i++) tag_q[i] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      addr_q      <= addr_d;
      rsp_valid_q <= tag_q[ROM_LAT];
      rsp_data_q  <= rsp_data_d;
      tag_q[0]    <= tag0_d;
      for (int unsigned i = 1; i <= ROM_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign rom_address = addr_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;

endmodule

// File: tb/tb_tile_rom_arbiter.sv
// Bench for tile_rom_arbiter: vector table for grants, scoreboard queue for responses.
module tb_tile_rom_arbiter;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 4;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*ADDR_W-1:0] req_addr = '0;
  logic [NREQ-1:0]        gnt;
  logic [ADDR_W-1:0]      rom_address;
  logic [DATA_W-1:0]      rom_q;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_data;

  tile_rom_arbiter #(
    .NREQ    (NREQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .ROM_LAT (1)
  ) dut (
    .vga_clk     (clk),
    .reset       (reset),
    .req         (req),
    .req_addr    (req_addr),
    .gnt         (gnt),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data)
  );

  always #5 clk = ~clk;

  // ROM on ~vga_clk with registered address and registered output; word = addr[3:0].
  logic [ADDR_W-1:0] rom_addr_lat;
  always @(negedge clk) begin
    rom_addr_lat <= rom_address;
    rom_q        <= rom_addr_lat[3:0];
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  typedef struct {
    logic [NREQ-1:0]   valid;
    logic [DATA_W-1:0] data;
    int unsigned       due;
  } exp_t;

  typedef struct {
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] addr;
    logic [NREQ-1:0]        gnt;
    string                  nm;
  } vec_t;

  exp_t              sb[$];
  vec_t              vecs[$];
  logic [DATA_W-1:0] last_data = '0;
  logic [ADDR_W-1:0] exp_rom_addr = '0;

  // Response monitor: every cycle either the scheduled response or an idle, holding output.
  always @(negedge clk) begin
    if (reset) begin
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'd0);
    end else if (sb.size() != 0 && sb[0].due == cyc) begin
      check("rsp_valid", 32'(rsp_valid), 32'(sb[0].valid));
      check("rsp_data", 32'(rsp_data), 32'(sb[0].data));
      last_data = sb[0].data;
      void'(sb.pop_front());
    end else begin
      if (sb.size() != 0 && sb[0].due < cyc) begin
        check("rsp_overdue_cycle", cyc, sb[0].due);
        void'(sb.pop_front());
      end
      check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      check("idle_rsp_hold", 32'(rsp_data), 32'(last_data));
    end
  end

  task automatic step(input logic [NREQ-1:0] r, input logic [NREQ*ADDR_W-1:0] a,
                      input logic [NREQ-1:0] eg, input string nm);
    logic [ADDR_W-1:0] wa;
    int unsigned       w;
    @(posedge clk);
    #1;
    check({nm, "_rom_address"}, 32'(rom_address), 32'(exp_rom_addr));
    req      = r;
    req_addr = a;
    #2;
    check({nm, "_gnt"}, 32'(gnt), 32'(eg));
    if (eg != '0) begin
      w = 0;
      for (int unsigned i = 0; i < NREQ; i++) if (eg[i]) w = i;
      wa = a[w*ADDR_W +: ADDR_W];
      sb.push_back('{eg, wa[3:0], cyc + 3});
      exp_rom_addr = wa;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset    = 1'b1;
    req      = '0;
    req_addr = '0;
    #1;
    check("reset_async_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_gnt", 32'(gnt), 32'd0);
    sb.delete();
    last_data    = '0;
    exp_rom_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic void add(input logic [NREQ-1:0] r, input logic [NREQ*ADDR_W-1:0] a,
                              input logic [NREQ-1:0] g, input string nm);
    vecs.push_back('{r, a, g, nm});
  endfunction

  localparam logic [NREQ*ADDR_W-1:0] ALL8 = {10'h00B, 10'h00A, 10'h009, 10'h008};
  localparam logic [NREQ*ADDR_W-1:0] ZA   = '0;

  initial begin
    // Rotation with every requester held, addr_i = i+8.
    for (int i = 0; i < 8; i++) begin
      logic [NREQ-1:0] g;
      g = NREQ'(1 << (i % 4));
      add(4'b1111, ALL8, g, "all_rot");
    end
    // Wrap from req3 back to req0, then req3 again, with back-to-back re-requests.
    add(4'b1000, {10'h3C3, 10'h000, 10'h000, 10'h101}, 4'b1000, "wrap_a");
    add(4'b1001, {10'h3C4, 10'h000, 10'h000, 10'h101}, 4'b0001, "wrap_b");
    add(4'b1001, {10'h3C4, 10'h000, 10'h000, 10'h102}, 4'b1000, "wrap_c");
    add(4'b0001, {10'h000, 10'h000, 10'h000, 10'h102}, 4'b0001, "wrap_d");
    // Bubbles: pulses with two idle cycles between.
    add(4'b0010, {10'h000, 10'h000, 10'h0E7, 10'h000}, 4'b0010, "bub_a");
    add(4'b0000, ZA, 4'b0000, "bub_gap");
    add(4'b0000, ZA, 4'b0000, "bub_gap");
    add(4'b0010, {10'h000, 10'h000, 10'h0E4, 10'h000}, 4'b0010, "bub_b");
    add(4'b0000, ZA, 4'b0000, "bub_gap");
    add(4'b0000, ZA, 4'b0000, "bub_gap");
    add(4'b0100, {10'h000, 10'h00D, 10'h000, 10'h000}, 4'b0100, "bub_c");
    add(4'b0000, ZA, 4'b0000, "bub_gap");
    add(4'b0000, ZA, 4'b0000, "bub_gap");
    // Withdraw: req1 loses to req0 and drops without being granted.
    add(4'b0011, {10'h000, 10'h000, 10'h006, 10'h005}, 4'b0001, "withdraw");
    add(4'b0000, ZA, 4'b0000, "withdraw_idle");
    add(4'b0000, ZA, 4'b0000, "withdraw_idle");
    add(4'b0000, ZA, 4'b0000, "withdraw_idle");
    // Single request to req2 at 2A5, then req2 alone every cycle.
    add(4'b0100, {10'h000, 10'h2A5, 10'h000, 10'h000}, 4'b0100, "single");
    add(4'b0100, {10'h000, 10'h2A6, 10'h000, 10'h000}, 4'b0100, "single_b2b");
    add(4'b0100, {10'h000, 10'h2A7, 10'h000, 10'h000}, 4'b0100, "single_b2b");
    add(4'b1100, {10'h3C9, 10'h2A8, 10'h000, 10'h000}, 4'b1000, "ptr_past");
    add(4'b0100, {10'h000, 10'h2A8, 10'h000, 10'h000}, 4'b0100, "ptr_past_b");
    add(4'b1001, {10'h301, 10'h000, 10'h000, 10'h300}, 4'b1000, "wrap_e");
    add(4'b1001, {10'h302, 10'h000, 10'h000, 10'h300}, 4'b0001, "wrap_f");
    for (int i = 0; i < 4; i++) add(4'b0000, ZA, 4'b0000, "drain");

    // Power-on reset.
    repeat (2) @(posedge clk);
    #1;
    check("por_gnt", 32'(gnt), 32'd0);
    check("por_rom_address", 32'(rom_address), 32'd0);
    reset = 1'b0;

    // Reset with three grants in flight: none may surface after release.
    step(4'b1111, ALL8, 4'b0001, "pre_rst");
    step(4'b1111, ALL8, 4'b0010, "pre_rst");
    step(4'b1111, ALL8, 4'b0100, "pre_rst");
    do_reset();
    for (int i = 0; i < 4; i++) step(4'b0000, ZA, 4'b0000, "post_rst_idle");
    step(4'b1111, ALL8, 4'b0001, "post_rst_first");
    for (int i = 0; i < 3; i++) step(4'b0000, ZA, 4'b0000, "post_rst_drain");

    do_reset();
    foreach (vecs[i]) step(vecs[i].req, vecs[i].addr, vecs[i].gnt, vecs[i].nm);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
